mat_tile_streamer: RTL

- Tile sequencer and row streamer that sits directly downstream of bram_manager.
- Issues the one-cycle request pulse and 6-bit tile select that bram_manager consumes.
- Captures each returned 16x128 int8 tile into a local buffer and streams it row by row, with valid/ready, to the MHA compute array.
- Once a tile is captured, prefetches the next tile so BRAM latency overlaps streaming.

---
 rtl/mha_pkg.sv | 37 +++
 rtl/tile_row_buffer.sv | 50 +++++
 rtl/mat_tile_streamer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mha_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mha_pkg
// Description : Shared tile geometry, row/tile data types and the request
//               state encoding used by the MHA tile streaming path.
// Revision    : 1.0 - initial release
// ============================================================================
package mha_pkg;

  localparam int ROWS  = 16;   // rows per tile
  localparam int COLS  = 128;  // int8 elements per row
  localparam int SEL_W = 6;    // tile select width (64 tiles)
  localparam int CNT_W = 7;    // tile counters must be able to hold 64
  localparam int ROW_W = 4;    // row index width

  localparam logic [CNT_W-1:0] MAX_TILES = 7'd64;

  // One row of int8 elements, element 0 first
  typedef logic [0:COLS-1][7:0] row_t;
  // One tile, row 0 first
  typedef row_t [0:ROWS-1] tile_t;

  // Request sequencer states
  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_WAIT = 2'd2,
    R_HOLD = 2'd3
  } req_state_e;

  // Tile counts above the bank size are saturated to the bank size
  function automatic logic [CNT_W-1:0] clamp_tiles(input logic [CNT_W-1:0] n);
    return (n > MAX_TILES) ? MAX_TILES : n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tile_row_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tile_row_buffer
// Description : Single-tile holding buffer. Captures a whole tile in one
//               cycle, presents one row selected by the read index, and keeps
//               a full flag where a capture overrides a drain in the same
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tile_row_buffer
  import mha_pkg::*;
(
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             cap_i,
  input  tile_t            tile_i,
  input  logic             drain_i,
  input  logic [ROW_W-1:0] rd_idx_i,
  output logic             full_o,
  output row_t             row_o
);

  tile_t tile_q;
  logic  full_q;

  // Whole-tile write on capture; contents cleared on reset
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      tile_q <= '0;
    end else if (cap_i) begin
      tile_q <= tile_i;
    end
  end

  // Full flag: a capture on the same edge as the last-row drain keeps it set
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      full_q <= 1'b0;
    end else if (cap_i) begin
      full_q <= 1'b1;
    end else if (drain_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign row_o  = tile_q[rd_idx_i];

endmodule
`default_nettype wire

// File: rtl/mat_tile_streamer.sv
`default_nettype none
// ============================================================================
// Module      : mat_tile_streamer
// Description : Requests consecutive tiles from bram_manager, captures each
//               returned tile and streams it row by row with valid/ready.
//               The next request is issued right after a capture so BRAM
//               latency overlaps streaming of the current tile.
// Revision    : 1.0 - initial release
// ============================================================================
module mat_tile_streamer
  import mha_pkg::*;
(
  input  logic             I_CLK,
  input  logic             I_RST_N,
  input  logic             I_START,
  input  logic [SEL_W-1:0] I_BASE_SEL,
  input  logic [CNT_W-1:0] I_NUM_TILES,
  output logic             O_BUSY,
  output logic             O_DONE,
  output logic             O_REQ_PULSE,
  output logic [SEL_W-1:0] O_REQ_SEL,
  input  logic             I_MAT_VLD,
  input  tile_t            I_MAT,
  output logic             O_ROW_VLD,
  output row_t             O_ROW,
  output logic [ROW_W-1:0] O_ROW_IDX,
  output logic [SEL_W-1:0] O_TILE_IDX,
  output logic             O_LAST,
  input  logic             I_ROW_RDY
);

  req_state_e       state_q, state_d;
  logic             busy_q;
  logic [SEL_W-1:0] base_q;
  logic [CNT_W-1:0] num_q;
  logic [CNT_W-1:0] req_cnt_q;
  logic [CNT_W-1:0] tile_cnt_q;
  logic [ROW_W-1:0] row_cnt_q;
  logic [SEL_W-1:0] sel_q;

  logic             w_start;
  logic             w_full;
  logic             w_hs;
  logic             w_row_end;
  logic             w_last;
  logic             w_can_cap;
  logic             w_cap;
  logic             w_more;
  logic [SEL_W-1:0] w_sel;

  assign w_start   = I_START && !busy_q && (I_NUM_TILES != '0);
  assign w_hs      = w_full && I_ROW_RDY;
  assign w_row_end = w_hs && (row_cnt_q == 4'd15);
  assign w_last    = w_full && (row_cnt_q == 4'd15) && (tile_cnt_q == (num_q - 7'd1));
  // The buffer can take a new tile when empty or when it is emptied this edge
  assign w_can_cap = !w_full || w_row_end;
  assign w_cap     = ((state_q == R_WAIT) || (state_q == R_HOLD)) && I_MAT_VLD && w_can_cap;
  assign w_more    = (req_cnt_q + 7'd1) < num_q;
  // 6-bit add wraps the select modulo 64
  assign w_sel     = base_q + req_cnt_q[SEL_W-1:0];

  tile_row_buffer u_buf (
    .I_CLK    (I_CLK),
    .I_RST_N  (I_RST_N),
    .cap_i    (w_cap),
    .tile_i   (I_MAT),
    .drain_i  (w_row_end),
    .rd_idx_i (row_cnt_q),
    .full_o   (w_full),
    .row_o    (O_ROW)
  );

  // Request FSM state register
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= R_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request FSM next state; O_VLD seen in R_REQ is stale and is ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      R_IDLE: if (w_start) state_d = R_REQ;
      R_REQ:  state_d = R_WAIT;
      R_WAIT: begin
        if (w_cap) begin
          state_d = w_more ? R_REQ : R_IDLE;
        end else if (I_MAT_VLD) begin
          state_d = R_HOLD;
        end
      end
      R_HOLD: if (w_cap) state_d = w_more ? R_REQ : R_IDLE;
      default: state_d = R_IDLE;
    endcase
  end

  // Request FSM outputs: select is live during the pulse and held afterwards
  always_comb begin
    O_REQ_PULSE = 1'b0;
    O_REQ_SEL   = sel_q;
    if (state_q == R_REQ) begin
      O_REQ_PULSE = 1'b1;
      O_REQ_SEL   = w_sel;
    end
  end

  // Hold the last issued select until the next request
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      sel_q <= '0;
    end else if (state_q == R_REQ) begin
      sel_q <= w_sel;
    end
  end

  // Run control: latch start parameters, busy until the final row handshake
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      busy_q <= 1'b0;
      base_q <= '0;
      num_q  <= '0;
    end else if (w_start) begin
      busy_q <= 1'b1;
      base_q <= I_BASE_SEL;
      num_q  <= clamp_tiles(I_NUM_TILES);
    end else if (w_row_end && w_last) begin
      busy_q <= 1'b0;
    end
  end

  // Request, tile and row counters
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      req_cnt_q  <= '0;
      tile_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else if (w_start) begin
      req_cnt_q  <= '0;
      tile_cnt_q <= '0;
      row_cnt_q  <= '0;
    end else begin
      if (w_cap) begin
        req_cnt_q <= req_cnt_q + 7'd1;
      end
      if (w_hs) begin
        row_cnt_q <= row_cnt_q + 4'd1;
      end
      if (w_row_end) begin
        tile_cnt_q <= w_last ? '0 : (tile_cnt_q + 7'd1);
      end
    end
  end

  assign O_BUSY     = busy_q;
  assign O_DONE     = w_hs && w_last;
  assign O_ROW_VLD  = w_full;
  assign O_ROW_IDX  = row_cnt_q;
  assign O_TILE_IDX = tile_cnt_q[SEL_W-1:0];
  assign O_LAST     = w_last;

endmodule
`default_nettype wire
